// File: rtl/seq_shift_unit.sv
// Multi-cycle LSL/LSR/ASR/ROR shifter: moves up to STEP bit positions per clock
// and reports the last bit shifted or rotated out of the word.
module seq_shift_unit #(
    parameter int DATA_WIDTH  = 24,
    parameter int SHAMT_WIDTH = 5,
    parameter int STEP        = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  logic [1:0]             mode,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  result,
    output logic                   carry_out
);

    // Handshake: start is accepted only while busy is low. The operation is
    // finished when done pulses for one cycle; result and carry_out stay valid
    // from that cycle until the next accepted start.

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] STEP_C = CW'(STEP);
    localparam logic [CW-1:0] DW_C   = CW'(DATA_WIDTH);
    localparam logic [31:0]   DW_U   = 32'(DATA_WIDTH);

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [1:0]      mode_q;
    logic [CW-1:0]   remaining;
    logic [CW-1:0]   eff_amt;
    logic [CW-1:0]   step_amt;
    logic [DATA_WIDTH-1:0] shifted;
    logic            carry_next;
    logic [IW-1:0]   lsl_idx;
    logic [IW-1:0]   low_idx;
    logic [31:0]     shamt_ext;

    // Effective amount: linear shifts saturate at the word width, ROR wraps.
    always_comb begin
        shamt_ext = 32'(shamt);
        eff_amt   = '0;
        if (mode == MODE_ROR) begin
            eff_amt = CW'(shamt_ext % DW_U);
        end else if (shamt_ext > DW_U) begin
            eff_amt = DW_C;
        end else begin
            eff_amt = CW'(shamt_ext);
        end
    end

    // One step of the datapath; step_amt is never 0 while in SHIFT.
    always_comb begin
        step_amt   = (remaining > STEP_C) ? STEP_C : remaining;
        lsl_idx    = IW'(DW_C - step_amt);
        low_idx    = IW'(step_amt - CW'(1));
        shifted    = result;
        carry_next = result[low_idx];
        case (mode_q)
            MODE_LSL: begin
                shifted    = result << step_amt;
                carry_next = result[lsl_idx];
            end
            MODE_LSR: shifted = result >> step_amt;
            MODE_ASR: shifted = $signed(result) >>> step_amt;
            MODE_ROR: shifted = (result >> step_amt) | (result << (DW_C - step_amt));
            default:  shifted = result;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (eff_amt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (remaining == step_amt) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_LSL;
            remaining <= '0;
            result    <= '0;
            carry_out <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            mode_q    <= mode;
            remaining <= eff_amt;
            result    <= data_in;
            carry_out <= 1'b0;
        end else if (state == ST_SHIFT) begin
            remaining <= remaining - step_amt;
            result    <= shifted;
            carry_out <= carry_next;
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule
